// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter sharing one multiply-reduce datapath between
// NUM_REQ convolution channels. A requester is granted for a whole burst of
// FILTER_SIZE beats; the burst is forwarded with the requester index, and each
// returning result is steered back to its owner using an in-order ID FIFO.
//
// Optional feature: define MAC_ARBITER_ERR_EN to add mac_arbiter_err_out, a
// sticky flag raised when a result shows up while no burst is outstanding.
module mac_arbiter #(
    parameter int DATA_WIDTH    = 12,
    parameter int FILTER_SIZE   = 5,
    parameter int NUM_REQ       = 4,
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              mac_arbiter_valid_in,
    output logic [NUM_REQ-1:0]              mac_arbiter_ready_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   mac_arbiter_dataa_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   mac_arbiter_datab_in,
    output logic                            mac_arbiter_valid_out,
    input  logic                            mac_arbiter_ready_out,
    output logic [DATA_WIDTH-1:0]           mac_arbiter_dataa_out,
    output logic [DATA_WIDTH-1:0]           mac_arbiter_datab_out,
    output logic [$clog2(NUM_REQ)-1:0]      mac_arbiter_id_out,
    output logic                            mac_arbiter_last_out,
    input  logic                            mac_arbiter_res_valid_in,
    output logic                            mac_arbiter_res_ready_in,
    input  logic [2*DATA_WIDTH-1:0]         mac_arbiter_res_data_in,
    output logic [NUM_REQ-1:0]              mac_arbiter_res_valid_out,
    input  logic [NUM_REQ-1:0]              mac_arbiter_res_ready_out,
`ifdef MAC_ARBITER_ERR_EN
    output logic                            mac_arbiter_err_out,
`endif
    output logic [2*DATA_WIDTH-1:0]         mac_arbiter_res_data_out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int FA_W  = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILTER_SIZE - 1);
    localparam logic [ID_W:0]    REQ_NUM   = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  REQ_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [FA_W-1:0]  FA_LAST   = FA_W'(ID_FIFO_DEPTH - 1);
    localparam logic [FA_W:0]    FIFO_FULL = (FA_W + 1)'(ID_FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // ID FIFO: requester index of every burst whose result is still pending
    logic [ID_W-1:0]   fifo_mem [ID_FIFO_DEPTH];
    logic [FA_W-1:0]   wr_ptr, rd_ptr;
    logic [FA_W:0]     fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic [ID_W-1:0]   head;
    logic              push, pop;

    // Cyclic search helpers
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [ID_W-1:0]      sel_off;
    logic [ID_W:0]        sel_sum;
    logic [ID_W-1:0]      sel_idx;
    logic                 any_valid;

    // Granted requester's operands
    logic [DATA_WIDTH-1:0] gnt_a, gnt_b;

    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];
    assign any_valid  = |mac_arbiter_valid_in;

    // Pick the first valid requester at or after ptr, wrapping around
    always_comb begin
        valid_dbl = {mac_arbiter_valid_in, mac_arbiter_valid_in};
        valid_rot = valid_dbl[{1'b0, ptr_q} +: NUM_REQ];
        sel_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) sel_off = ID_W'(k);
        end
        sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
        if (sel_sum >= REQ_NUM) sel_sum = sel_sum - REQ_NUM;
        sel_idx = sel_sum[ID_W-1:0];
    end

    // Operand mux driven by the current grant
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == ID_W'(k)) begin
                gnt_a = mac_arbiter_dataa_in[k*DATA_WIDTH +: DATA_WIDTH];
                gnt_b = mac_arbiter_datab_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM next state, beat counting and forward-path outputs
    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        ptr_d                 = ptr_q;
        cnt_d                 = cnt_q;
        push                  = 1'b0;
        mac_arbiter_valid_out = 1'b0;
        mac_arbiter_ready_in  = '0;
        mac_arbiter_dataa_out = '0;
        mac_arbiter_datab_out = '0;
        mac_arbiter_id_out    = '0;
        mac_arbiter_last_out  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Full FIFO means no room to track another result: wait here
                if (any_valid && !fifo_full) begin
                    grant_d = sel_idx;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                mac_arbiter_valid_out         = mac_arbiter_valid_in[grant_q];
                mac_arbiter_ready_in[grant_q] = mac_arbiter_ready_out;
                mac_arbiter_dataa_out         = gnt_a;
                mac_arbiter_datab_out         = gnt_b;
                mac_arbiter_id_out            = grant_q;
                mac_arbiter_last_out          = mac_arbiter_valid_out & (cnt_q == CNT_LAST);
                // Grant is held through valid gaps until the final beat transfers
                if (mac_arbiter_valid_out && mac_arbiter_ready_out) begin
                    if (cnt_q == CNT_LAST) begin
                        push    = 1'b1;
                        ptr_d   = (grant_q == REQ_LAST) ? '0 : grant_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and arbitration state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Return path: only the head owner sees the result as valid
    always_comb begin
        mac_arbiter_res_valid_out       = '0;
        mac_arbiter_res_valid_out[head] = mac_arbiter_res_valid_in & ~fifo_empty;
        mac_arbiter_res_ready_in        = ~fifo_empty & mac_arbiter_res_ready_out[head];
    end

    assign mac_arbiter_res_data_out = mac_arbiter_res_data_in;
    assign pop = mac_arbiter_res_valid_in & mac_arbiter_res_ready_in;

    // ID FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= grant_q;
    end

    // ID FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == FA_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == FA_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef MAC_ARBITER_ERR_EN
    logic err_q;

    // Sticky flag for a result arriving with nothing outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (mac_arbiter_res_valid_in && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign mac_arbiter_err_out = err_q;
`endif

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: randomized bench for mac_arbiter with a queue-based
// reference model of grants, bursts and outstanding result IDs.
module tb_mac_arbiter;

    localparam int DW    = 12;
    localparam int FS    = 5;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;
    localparam int VW    = 2*N + 4*DW + IDW + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       valid_in;
    logic [N-1:0]       ready_in;
    logic [N*DW-1:0]    dataa_in;
    logic [N*DW-1:0]    datab_in;
    logic               valid_out;
    logic               ready_out;
    logic [DW-1:0]      dataa_out;
    logic [DW-1:0]      datab_out;
    logic [IDW-1:0]     id_out;
    logic               last_out;
    logic               res_valid_in;
    logic               res_ready_in;
    logic [2*DW-1:0]    res_data_in;
    logic [N-1:0]       res_valid_out;
    logic [N-1:0]       res_ready_out;
    logic [2*DW-1:0]    res_data_out;
`ifdef MAC_ARBITER_ERR_EN
    logic               err_out;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit  m_busy;
    int  m_grant;
    int  m_beats;
    int  m_ptr;
    int  m_ids[$];
    bit  m_err;

    mac_arbiter #(
        .DATA_WIDTH(DW), .FILTER_SIZE(FS), .NUM_REQ(N), .ID_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .mac_arbiter_valid_in      (valid_in),
        .mac_arbiter_ready_in      (ready_in),
        .mac_arbiter_dataa_in      (dataa_in),
        .mac_arbiter_datab_in      (datab_in),
        .mac_arbiter_valid_out     (valid_out),
        .mac_arbiter_ready_out     (ready_out),
        .mac_arbiter_dataa_out     (dataa_out),
        .mac_arbiter_datab_out     (datab_out),
        .mac_arbiter_id_out        (id_out),
        .mac_arbiter_last_out      (last_out),
        .mac_arbiter_res_valid_in  (res_valid_in),
        .mac_arbiter_res_ready_in  (res_ready_in),
        .mac_arbiter_res_data_in   (res_data_in),
        .mac_arbiter_res_valid_out (res_valid_out),
        .mac_arbiter_res_ready_out (res_ready_out),
`ifdef MAC_ARBITER_ERR_EN
        .mac_arbiter_err_out       (err_out),
`endif
        .mac_arbiter_res_data_out  (res_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] dut_vec();
        return {ready_in, valid_out, dataa_out, datab_out, id_out, last_out,
                res_ready_in, res_valid_out, res_data_out};
    endfunction

    // Expected outputs derived from the model's view of who owns the datapath
    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]   rdy  = '0;
        logic           vo   = 1'b0;
        logic [DW-1:0]  a    = '0;
        logic [DW-1:0]  b    = '0;
        logic [IDW-1:0] id   = '0;
        logic           last = 1'b0;
        logic [N-1:0]   rvo  = '0;
        logic           rri  = 1'b0;
        if (m_busy) begin
            vo         = valid_in[m_grant];
            rdy[m_grant] = ready_out;
            a          = dataa_in[m_grant*DW +: DW];
            b          = datab_in[m_grant*DW +: DW];
            id         = IDW'(m_grant);
            last       = vo && (m_beats == FS - 1);
        end
        if (m_ids.size() > 0) begin
            rvo[m_ids[0]] = res_valid_in;
            rri           = res_ready_out[m_ids[0]];
        end
        return {rdy, vo, a, b, id, last, rri, rvo, res_data_in};
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_grant = 0;
        m_beats = 0;
        m_ptr   = 0;
        m_ids.delete();
        m_err   = 0;
    endtask

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_step();
        bit pop;
        pop = 0;
        if (m_ids.size() > 0) pop = res_valid_in && res_ready_out[m_ids[0]];
        if (res_valid_in && m_ids.size() == 0) m_err = 1;
        if (m_busy) begin
            if (valid_in[m_grant] && ready_out) begin
                m_beats++;
                if (m_beats == FS) begin
                    m_ids.push_back(m_grant);
                    m_ptr  = (m_grant + 1) % N;
                    m_busy = 0;
                end
            end
        end else if (m_ids.size() < DEPTH && valid_in != '0) begin
            for (int k = 0; k < N; k++) begin
                if (valid_in[(m_ptr + k) % N]) begin
                    m_grant = (m_ptr + k) % N;
                    break;
                end
            end
            m_busy  = 1;
            m_beats = 0;
        end
        if (pop) void'(m_ids.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            dataa_in[k*DW +: DW] = DW'($urandom);
            datab_in[k*DW +: DW] = DW'($urandom);
        end
        res_data_in = (2*DW)'($urandom);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = '1; ready_out = 1'b1; res_valid_in = 1'b1; res_ready_out = '1;
        rand_data();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_outputs act=%h exp=%h", dut_vec(), exp_vec());
        end
`ifdef MAC_ARBITER_ERR_EN
        total++;
        if (err_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_err act=%b exp=0", err_out);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        res_valid_in = 1'b0;
        valid_in = '0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        int hs = 0;
        int last_cyc = -1;
        bit id_ok = 1;
        reset_dut();
        valid_in = 4'b0100; ready_out = 1'b1; res_valid_in = 1'b0; res_ready_out = '0;
        for (int c = 0; c < FS + 1; c++) begin
            rand_data();
            #1;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single cyc=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (valid_out && ready_out) begin
                hs++;
                if (id_out !== 2'd2) id_ok = 0;
            end
            if (last_out) last_cyc = c;
            step();
        end
        valid_in = '0;
        total++;
        if (hs != FS || !id_ok) begin
            bad++;
            $display("FAIL single_beats act=%0d id_ok=%0d exp=%0d id_ok=1", hs, id_ok, FS);
        end
        total++;
        if (last_cyc != FS) begin
            bad++;
            $display("FAIL single_last_cycle act=%0d exp=%0d", last_cyc, FS);
        end
        res_valid_in = 1'b1; res_ready_out = 4'b1011;
        #1;
        total++;
        if (res_valid_out !== 4'b0100 || res_ready_in !== 1'b0) begin
            bad++;
            $display("FAIL single_route act=%b/%b exp=0100/0", res_valid_out, res_ready_in);
        end
        step();
        res_ready_out = '1;
        #1;
        total++;
        if (res_ready_in !== 1'b1) begin
            bad++;
            $display("FAIL single_pop_ready act=%b exp=1", res_ready_in);
        end
        step();
        #1;
        total++;
        if (res_ready_in !== 1'b0 || res_valid_out !== 4'b0000) begin
            bad++;
            $display("FAIL single_empty act=%b/%b exp=0/0000", res_ready_in, res_valid_out);
        end
        res_valid_in = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int order[$];
        int cyc[$];
        reset_dut();
        valid_in = '1; ready_out = 1'b1; res_valid_in = 1'b1; res_ready_out = '1;
        for (int c = 0; c < 5*(FS + 1); c++) begin
            rand_data();
            #1;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL round_robin cyc=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (last_out && ready_out) begin
                order.push_back(int'(id_out));
                cyc.push_back(c);
            end
            step();
        end
        total++;
        if (order.size() != 5) begin
            bad++;
            $display("FAIL rr_burst_count act=%0d exp=5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (order[k] != k % N) begin
                    bad++;
                    $display("FAIL rr_order idx=%0d act=%0d exp=%0d", k, order[k], k % N);
                end
                if (k > 0) begin
                    total++;
                    if (cyc[k] - cyc[k-1] != FS + 1) begin
                        bad++;
                        $display("FAIL rr_period idx=%0d act=%0d exp=%0d", k, cyc[k] - cyc[k-1], FS + 1);
                    end
                end
            end
        end
        valid_in = '0; res_valid_in = 1'b0;
    endtask

    task automatic test_stall();
        int  hs = 0;
        int  lasts = 0;
        bit  prev_hs = 1;
        reset_dut();
        valid_in = '1; res_valid_in = 1'b1; res_ready_out = '1;
        for (int c = 0; c < 60 && lasts < 2; c++) begin
            ready_out = (c % 2 == 0);
            if (prev_hs) rand_data();
            #1;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL stall cyc=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            prev_hs = valid_out && ready_out;
            if (prev_hs) hs++;
            if (prev_hs && last_out) lasts++;
            step();
        end
        total++;
        if (lasts != 2 || hs != 2*FS) begin
            bad++;
            $display("FAIL stall_handshakes act=%0d/%0d exp=%0d/2", hs, lasts, 2*FS);
        end
        valid_in = '0; res_valid_in = 1'b0; ready_out = 1'b1;
    endtask

    task automatic test_fifo_full();
        reset_dut();
        valid_in = '1; ready_out = 1'b1; res_valid_in = 1'b0; res_ready_out = '0;
        for (int c = 0; c < 4*(FS + 1) + 5; c++) begin
            rand_data();
            #1;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fifo_full cyc=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c >= 4*(FS + 1)) begin
                total++;
                if (valid_out !== 1'b0 || ready_in !== '0) begin
                    bad++;
                    $display("FAIL full_hold cyc=%0d act=%b/%b exp=0/0000", c, valid_out, ready_in);
                end
            end
            step();
        end
        res_valid_in = 1'b1; res_ready_out = '1;
        #1;
        total++;
        if (res_ready_in !== 1'b1 || res_valid_out !== 4'b0001 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL full_pop act=%b/%b/%b exp=1/0001/0", res_ready_in, res_valid_out, valid_out);
        end
        step();
        res_valid_in = 1'b0;
        #1;
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL full_arb_cycle act=%b exp=0", valid_out);
        end
        step();
        #1;
        total++;
        if (valid_out !== 1'b1 || id_out !== 2'd0) begin
            bad++;
            $display("FAIL full_regrant act=%b/%0d exp=1/0", valid_out, id_out);
        end
        step();
        valid_in = '0;
    endtask

    task automatic test_return();
        reset_dut();
        valid_in = 4'b0010; ready_out = 1'b1; res_valid_in = 1'b0; res_ready_out = 4'b1101;
        for (int c = 0; c < FS + 1; c++) begin
            rand_data();
            #1;
            step();
        end
        valid_in = '0;
        res_valid_in = 1'b1; res_data_in = 24'h000ABC;
        #1;
        total++;
        if (res_valid_out !== 4'b0010 || res_ready_in !== 1'b0 || res_data_out !== 24'h000ABC) begin
            bad++;
            $display("FAIL ret_head1 act=%b/%b/%h exp=0010/0/000abc", res_valid_out, res_ready_in, res_data_out);
        end
        step();
        valid_in = 4'b1000;
        for (int c = 0; c < FS + 1; c++) begin
            res_ready_out = (c == FS) ? 4'b1111 : 4'b1101;
            #1;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL ret_burst cyc=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c == FS) begin
                total++;
                if (last_out !== 1'b1 || res_ready_in !== 1'b1) begin
                    bad++;
                    $display("FAIL ret_push_pop act=%b/%b exp=1/1", last_out, res_ready_in);
                end
            end
            step();
        end
        valid_in = '0; res_ready_out = '0;
        #1;
        total++;
        if (res_valid_out !== 4'b1000 || res_ready_in !== 1'b0) begin
            bad++;
            $display("FAIL ret_head3 act=%b/%b exp=1000/0", res_valid_out, res_ready_in);
        end
        step();
        res_ready_out = '1;
        #1;
        step();
        #1;
        total++;
        if (res_ready_in !== 1'b0 || res_valid_out !== 4'b0000) begin
            bad++;
            $display("FAIL ret_drained act=%b/%b exp=0/0000", res_ready_in, res_valid_out);
        end
        res_valid_in = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        valid_in = 4'b0100; ready_out = 1'b1; res_valid_in = 1'b0; res_ready_out = '0;
        for (int c = 0; c < FS + 1; c++) begin
            rand_data();
            #1;
            step();
        end
        valid_in = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            step();
        end
        #1;
        total++;
        if (valid_out !== 1'b1 || ready_in !== 4'b0001 || id_out !== 2'd0) begin
            bad++;
            $display("FAIL mid_beat3 act=%b/%b/%0d exp=1/0001/0", valid_out, ready_in, id_out);
        end
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (valid_out !== 1'b0 || ready_in !== '0 || last_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_drop act=%b/%b/%b exp=0/0000/0", valid_out, ready_in, last_out);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        valid_in = 4'b1010; res_valid_in = 1'b1; res_ready_out = '1;
        #1;
        total++;
        if (res_ready_in !== 1'b0 || res_valid_out !== 4'b0000) begin
            bad++;
            $display("FAIL mid_ids_discarded act=%b/%b exp=0/0000", res_ready_in, res_valid_out);
        end
        step();
        #1;
        total++;
        if (valid_out !== 1'b1 || id_out !== 2'd1) begin
            bad++;
            $display("FAIL mid_first_grant act=%b/%0d exp=1/1", valid_out, id_out);
        end
        step();
        valid_in = '0; res_valid_in = 1'b0;
    endtask

`ifdef MAC_ARBITER_ERR_EN
    task automatic test_err();
        reset_dut();
        valid_in = '0; res_valid_in = 1'b0;
        #1;
        total++;
        if (err_out !== 1'b0) begin
            bad++;
            $display("FAIL err_clear act=%b exp=0", err_out);
        end
        step();
        res_valid_in = 1'b1;
        #1;
        step();
        res_valid_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (err_out !== 1'b1) begin
                bad++;
                $display("FAIL err_sticky cyc=%0d act=%b exp=1", c, err_out);
            end
            step();
        end
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (err_out !== 1'b0) begin
            bad++;
            $display("FAIL err_reset act=%b exp=0", err_out);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            valid_in      = N'($urandom);
            ready_out     = ($urandom % 4) != 0;
            res_valid_in  = ($urandom % 2) != 0;
            res_ready_out = N'($urandom);
            rand_data();
            #1;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d act=%h exp=%h", c, dut_vec(), exp_vec());
            end
`ifdef MAC_ARBITER_ERR_EN
            total++;
            if (err_out !== m_err) begin
                bad++;
                $display("FAIL random_err cyc=%0d act=%b exp=%b", c, err_out, m_err);
            end
`endif
            step();
        end
        valid_in = '0; res_valid_in = 1'b0;
    endtask

    initial begin
        valid_in = '0; ready_out = 1'b0; res_valid_in = 1'b0; res_ready_out = '0;
        dataa_in = '0; datab_in = '0; res_data_in = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_fifo_full();
        test_return();
        test_reset_mid();
`ifdef MAC_ARBITER_ERR_EN
        test_err();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Round-robin arbiter that shares a single multiply-reduce datapath between NUM_REQ convolution channels. Each requester presents a serial stream of FILTER_SIZE (kernel element, weight) beats. The arbiter grants one requester for a whole filter burst, forwards that burst to the shared mult_reduce, and tags it with the requester index. It then routes each accumulated result back to its originating channel, using an in-order ID FIFO to track which channel each result belongs to.

## Interface
- DATA_WIDTH, 12, width of each operand
- FILTER_SIZE, 5, beats per burst (one filter)
- NUM_REQ, 4, number of requesters (≥2)
- ID_FIFO_DEPTH, 4, number of bursts that may be outstanding in the datapath (power of 2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mac_arbiter_valid_in  in  NUM_REQ  per-requester beat valid
- mac_arbiter_ready_in  out  NUM_REQ  per-requester beat ready
- mac_arbiter_dataa_in  in  NUM_REQ×DATA_WIDTH  kernel element per requester
- mac_arbiter_datab_in  in  NUM_REQ×DATA_WIDTH  weight per requester
- mac_arbiter_valid_out  out  1  beat valid to mult_reduce
- mac_arbiter_ready_out  in  1  beat ready from mult_reduce
- mac_arbiter_dataa_out  out  DATA_WIDTH  granted kernel element
- mac_arbiter_datab_out  out  DATA_WIDTH  granted weight
- mac_arbiter_id_out  out  clog2(NUM_REQ)  granted requester index
- mac_arbiter_last_out  out  1  final beat of the burst
- mac_arbiter_res_valid_in  in  1  result valid from mult_reduce
- mac_arbiter_res_ready_in  out  1  result ready to mult_reduce
- mac_arbiter_res_data_in  in  2×DATA_WIDTH  accumulated result
- mac_arbiter_res_valid_out  out  NUM_REQ  per-requester result valid
- mac_arbiter_res_ready_out  in  NUM_REQ  per-requester result ready
- mac_arbiter_res_data_out  out  2×DATA_WIDTH  result, broadcast to all requesters

## Operation
- Two-state FSM: IDLE and BURST. Internal registers:
  - grant: clog2(NUM_REQ) bits.
  - priority pointer ptr.
  - beat counter cnt: clog2(FILTER_SIZE) bits.
  - ID FIFO: ID_FIFO_DEPTH entries of clog2(NUM_REQ) bits.
- IDLE:
  - Select the first index at or after ptr, searching cyclically, with valid_in asserted.
  - If any requester is valid and the FIFO is not full: grant <= selected index, cnt <= 0, go to BURST.
  - If the FIFO is full, hold in IDLE.
  - No beat transfers in IDLE.
- BURST: pass-through from the granted requester.
  - valid_out = valid_in[grant].
  - ready_in[grant] = ready_out; all other ready_in bits are 0.
  - dataa/datab_out follow the granted requester; id_out = grant.
  - last_out = valid_out & (cnt == FILTER_SIZE-1).
- On each beat handshake (valid_out & ready_out): cnt increments.
- On the last-beat handshake:
  - push grant into the ID FIFO;
  - ptr <= (grant+1) mod NUM_REQ;
  - cnt <= 0;
  - go to IDLE.
- A granted requester that drops valid mid-burst keeps the grant; the burst is never abandoned.
- Return path, with head = FIFO head entry:
  - res_valid_out[i] = res_valid_in & !empty & (head == i).
  - res_ready_in = !empty & res_ready_out[head].
  - res_data_out = res_data_in.
  - The FIFO pops on a res_valid_in & res_ready_in handshake.
- The FIFO supports a push and a pop in the same cycle: count is unchanged and pointers wrap modulo ID_FIFO_DEPTH.
- A result arriving while the FIFO is empty is stalled (res_ready_in = 0).

## Timing
- Reset values:
  - FSM = IDLE; ptr, grant, cnt, FIFO pointers and FIFO count = 0.
  - All ready_in, valid_out, res_valid_out, res_ready_in and last_out = 0.
  - id_out = 0; dataa_out and datab_out = 0.
- All outputs are combinational from state and inputs; data outputs are forced to 0 in IDLE.
- Asserting reset mid-burst clears the FSM immediately, so all valid and ready outputs drop asynchronously. Partial bursts and outstanding IDs are discarded.
- Arbitration costs one idle cycle per burst. Back-to-back bursts from continuously valid requesters therefore take FILTER_SIZE+1 cycles each.
- Forward path latency is 0 cycles in BURST; the return path is also 0-cycle pass-through.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…

## Configuration
- MAC_ARBITER_ERR_EN:
  - When defined, adds output port mac_arbiter_err_out (1 bit). It is a sticky flag that sets on any cycle where res_valid_in = 1 while the ID FIFO is empty.
  - The flag clears only on reset.
  - When not defined, the port and its logic are absent, and an unexpected result simply stalls.

## Test plan
- Requester 2 alone valid, ready_out = 1 (FILTER_SIZE = 5) -> 1 idle cycle, then 5 beats with id_out = 2 and last_out on beat 5. ID FIFO count rises to 1.
- All 4 requesters continuously valid -> grant order 0,1,2,3,0; each burst is 5 beats followed by 1 idle cycle.
- ready_out toggled 1,0,1,0 mid-burst -> data held stable while stalled; cnt advances only on handshakes; exactly 5 handshakes per burst.
- ID FIFO full with 4 outstanding bursts and no results -> arbiter holds IDLE. Return one result -> next grant follows 1 cycle later.
- Result data 0x00ABC with FIFO head = 1 and res_ready_out[1] = 0 -> res_valid_out = 0010 and res_ready_in = 0. Set res_ready_out[1] = 1 -> FIFO pops; simultaneous push and pop leave the count unchanged.
- Reset asserted on beat 3 -> valid_out and ready_in drop the same cycle. After release, the first grant goes to the lowest valid index (ptr = 0). With MAC_ARBITER_ERR_EN defined, res_valid_in while the FIFO is empty -> err_out = 1 and stays set until reset.
